// File: rtl/output_display.sv
`default_nettype none
// ============================================================================
// Module   : output_display
// Purpose  : Output register with sequential binary-to-BCD conversion driving a
//            4-digit multiplexed seven-segment display.
// Revision : 1.0
// ============================================================================
module output_display #(
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus,
    input  logic       out_en,
    input  logic       signed_mode,
    output logic [7:0] value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(SCAN_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] C_BLANK = 4'hA;
    localparam logic [3:0] C_MINUS = 4'hB;

    logic [1:0]    state_q, state_d;
    logic [7:0]    value_q, value_d;
    logic          sign_q, sign_d;
    logic [2:0]    iter_q, iter_d;
    // {hundreds, tens, ones, binary} shifted left once per iteration
    logic [19:0]   dd_q, dd_d;
    logic [15:0]   digits_q, digits_d;
    logic          busy_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;

    logic          w_neg;
    logic [7:0]    w_mag;
    logic [19:0]   w_adj;
    logic [3:0]    w_hund, w_tens, w_ones;
    logic [3:0]    w_code;
    logic [6:0]    w_seg;
    logic [3:0]    w_an;

    assign w_neg = signed_mode & bus[7];
    assign w_mag = w_neg ? (~bus + 8'd1) : bus;

    assign w_adj[7:0]   = dd_q[7:0];
    assign w_adj[11:8]  = (dd_q[11:8]  >= 4'd5) ? dd_q[11:8]  + 4'd3 : dd_q[11:8];
    assign w_adj[15:12] = (dd_q[15:12] >= 4'd5) ? dd_q[15:12] + 4'd3 : dd_q[15:12];
    assign w_adj[19:16] = (dd_q[19:16] >= 4'd5) ? dd_q[19:16] + 4'd3 : dd_q[19:16];

    assign w_hund = dd_q[19:16];
    assign w_tens = dd_q[15:12];
    assign w_ones = dd_q[11:8];

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        sign_d   = sign_q;
        iter_d   = iter_q;
        dd_d     = dd_q;
        digits_d = digits_q;
        // A load always wins, restarting any conversion already under way
        if (out_en) begin
            value_d = bus;
            sign_d  = w_neg;
            dd_d    = {12'd0, w_mag};
            iter_d  = 3'd0;
            state_d = S_CONV;
        end else begin
            case (state_q)
                S_CONV: begin
                    dd_d   = {w_adj[18:0], 1'b0};
                    iter_d = iter_q + 3'd1;
                    if (iter_q == 3'd7) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    digits_d[15:12] = sign_q ? C_MINUS : C_BLANK;
                    digits_d[11:8]  = (w_hund == 4'd0) ? C_BLANK : w_hund;
                    digits_d[7:4]   = ((w_hund == 4'd0) && (w_tens == 4'd0)) ? C_BLANK : w_tens;
                    digits_d[3:0]   = w_ones;
                    state_d         = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            value_q  <= 8'd0;
            sign_q   <= 1'b0;
            iter_q   <= 3'd0;
            dd_q     <= 20'd0;
            digits_q <= {C_BLANK, C_BLANK, C_BLANK, 4'd0};
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            sign_q   <= sign_d;
            iter_q   <= iter_d;
            dd_q     <= dd_d;
            digits_q <= digits_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else if (presc_q == C_PRESC_MAX) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign w_code = digits_q[idx_q*4 +: 4];
    assign w_an   = 4'b0001 << idx_q;

    always_comb begin
        case (w_code)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            C_MINUS: w_seg = 7'h40;
            default: w_seg = 7'h00;
        endcase
    end

    // Both outputs derive from the same index register, so they switch together
    assign seg   = w_seg ^ {7{SEG_ACTIVE_LOW}};
    assign an    = w_an ^ {4{SEG_ACTIVE_LOW}};
    assign value = value_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_output_display.sv
`default_nettype none
// Directed self-checking bench for output_display (SCAN_DIV=4, active-low outputs).
module tb_output_display;

    logic       clk;
    logic       rst;
    logic [7:0] bus;
    logic       out_en;
    logic       signed_mode;
    logic [7:0] value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    // Active-low segment constants {g,f,e,d,c,b,a}
    localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P4 = 7'h19, P5 = 7'h12;
    localparam logic [6:0] P6 = 7'h02, P7 = 7'h78, P8 = 7'h00, P9 = 7'h10;
    localparam logic [6:0] PB = 7'h7F, PM = 7'h3F;

    output_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .out_en(out_en), .signed_mode(signed_mode),
        .value(value), .busy(busy), .seg(seg), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load(input logic [7:0] b, input logic sm);
        @(negedge clk);
        bus = b; signed_mode = sm; out_en = 1'b1;
        @(negedge clk);
        out_en = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    // Captures segs as {digit3, digit2, digit1, digit0}
    task automatic read_digits(output logic [27:0] segs, output logic ok);
        logic       found;
        logic [3:0] exp_an;
        ok = 1'b1; segs = '0;
        for (int k = 0; k < 4; k++) begin
            found  = 1'b0;
            exp_an = ~(4'b0001 << k);
            for (int t = 0; t < 40 && !found; t++) begin
                @(negedge clk);
                if (an === exp_an) begin
                    segs[k*7 +: 7] = seg;
                    found = 1'b1;
                end
            end
            if (!found) ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_an;
        rst = 1'b1; bus = 8'hxx; out_en = 1'bx; signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (value !== 8'h00 || busy !== 1'b0 || an !== 4'b1110 || seg !== P0) begin
            n_fail++;
            $display("FAIL reset_state: value=%h busy=%b an=%b seg=%h required 00 0 1110 %h",
                     value, busy, an, seg, P0);
        end
        bus = 8'h00; out_en = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            n_checks++;
            if (an !== exp_an) begin
                n_fail++;
                $display("FAIL scan_an[%0d]: got %b required %b", k, an, exp_an);
            end
            if (exp_an != 4'b1110) begin
                n_checks++;
                if (seg !== PB) begin
                    n_fail++;
                    $display("FAIL reset_blank[%0d]: got %h required %h", k, seg, PB);
                end
            end
        end
    endtask

    task automatic test_unsigned_latency;
        logic [27:0] segs;
        logic        ok;
        load(8'hFF, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || value !== 8'hFF) begin
            n_fail++;
            $display("FAIL load_ff: busy=%b value=%h required 1 ff", busy, value);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_during[%0d]: got %b required 1", i, busy);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || value !== 8'hFF) begin
            n_fail++;
            $display("FAIL busy_end: busy=%b value=%h required 0 ff", busy, value);
        end
        read_digits(segs, ok);
        n_checks++;
        if (!ok || segs !== {PB, P2, P5, P5}) begin
            n_fail++;
            $display("FAIL disp_255: got %h required %h", segs, {PB, P2, P5, P5});
        end
    endtask

    task automatic test_signed;
        logic [7:0]  vb [3];
        logic        vs [3];
        logic [27:0] ve [3];
        logic [27:0] segs;
        logic        ok;
        vb[0] = 8'h80; vs[0] = 1'b1; ve[0] = {PM, P1, P2, P8};
        vb[1] = 8'hF6; vs[1] = 1'b1; ve[1] = {PM, PB, P1, P0};
        vb[2] = 8'hF6; vs[2] = 1'b0; ve[2] = {PB, P2, P4, P6};
        for (int i = 0; i < 3; i++) begin
            load(vb[i], vs[i]);
            wait_idle(ok);
            read_digits(segs, ok);
            n_checks++;
            if (!ok || segs !== ve[i]) begin
                n_fail++;
                $display("FAIL disp_signed[%0d]: got %h required %h", i, segs, ve[i]);
            end
        end
    endtask

    task automatic test_retrigger;
        logic [27:0] segs;
        logic        ok;
        load(8'h07, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || seg === P7) begin
                n_fail++;
                $display("FAIL retrig_pre[%0d]: busy=%b seg=%h required busy 1 and no 7", i, busy, seg);
            end
        end
        bus = 8'h63; out_en = 1'b1;
        @(negedge clk);
        out_en = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || value !== 8'h63) begin
            n_fail++;
            $display("FAIL retrig_load: busy=%b value=%h required 1 63", busy, value);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || seg === P7) begin
                n_fail++;
                $display("FAIL retrig_conv[%0d]: busy=%b seg=%h required busy 1 and no 7", i, busy, seg);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL retrig_end: busy got %b required 0", busy);
        end
        read_digits(segs, ok);
        n_checks++;
        if (!ok || segs !== {PB, PB, P9, P9}) begin
            n_fail++;
            $display("FAIL disp_99: got %h required %h", segs, {PB, PB, P9, P9});
        end
    endtask

    task automatic test_back_to_back;
        logic [27:0] segs;
        logic        ok;
        @(negedge clk);
        signed_mode = 1'b0; out_en = 1'b1; bus = 8'h05;
        @(negedge clk); bus = 8'h0C;
        @(negedge clk); bus = 8'h11;
        @(negedge clk); out_en = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok || value !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_value: got %h required 11 (idle=%b)", value, ok);
        end
        read_digits(segs, ok);
        n_checks++;
        if (!ok || segs !== {PB, PB, P1, P7}) begin
            n_fail++;
            $display("FAIL disp_17: got %h required %h", segs, {PB, PB, P1, P7});
        end
    endtask

    task automatic test_zero_signed;
        logic [27:0] segs;
        logic        ok;
        load(8'h00, 1'b1);
        wait_idle(ok);
        read_digits(segs, ok);
        n_checks++;
        if (!ok || segs !== {PB, PB, PB, P0}) begin
            n_fail++;
            $display("FAIL disp_0: got %h required %h", segs, {PB, PB, PB, P0});
        end
    endtask

    task automatic test_hold_signed_mode;
        logic [27:0] segs;
        logic        ok;
        load(8'h2A, 1'b0);
        wait_idle(ok);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            signed_mode = ~signed_mode;
        end
        n_checks++;
        if (busy !== 1'b0 || value !== 8'h2A) begin
            n_fail++;
            $display("FAIL hold_state: busy=%b value=%h required 0 2a", busy, value);
        end
        read_digits(segs, ok);
        n_checks++;
        if (!ok || segs !== {PB, PB, P4, P2}) begin
            n_fail++;
            $display("FAIL disp_42: got %h required %h", segs, {PB, PB, P4, P2});
        end
    endtask

    task automatic test_reset_mid;
        logic        found;
        logic [27:0] segs;
        logic        ok;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (an === 4'b1101) found = 1'b1;
        end
        load(8'h63, 1'b0);
        @(negedge clk);
        n_checks++;
        if (!found || busy !== 1'b1 || an !== 4'b1101) begin
            n_fail++;
            $display("FAIL pre_reset: found=%b busy=%b an=%b required 1 1 1101", found, busy, an);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (value !== 8'h00 || busy !== 1'b0 || an !== 4'b1110 || seg !== P0) begin
            n_fail++;
            $display("FAIL async_reset: value=%h busy=%b an=%b seg=%h required 00 0 1110 %h",
                     value, busy, an, seg, P0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_busy: got %b required 0", busy);
        end
        read_digits(segs, ok);
        n_checks++;
        if (!ok || segs !== {PB, PB, PB, P0}) begin
            n_fail++;
            $display("FAIL post_reset_disp: got %h required %h", segs, {PB, PB, PB, P0});
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_retrigger();
        test_back_to_back();
        test_zero_signed();
        test_hold_signed_mode();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
